// File: rtl/core_ex_wb_reg.sv
// Execute-to-writeback boundary: two-entry skid buffer plus architectural flags (cf/of/zf).
// Latency: an accepted entry appears on wb_* one cycle later when the buffer holds no older entry.
// Backpressure: wb_stall parks entries in OUT/SKID; ex_ready drops only when both are occupied.
// Optional operand forwarding from the held entries is built when I2D_EX_WB_FWD_EN is defined.

package core_ex_wb_pkg;
    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
    } flag_t;
endpackage

module core_ex_wb_reg
    import core_ex_wb_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wr_en,
    input  logic                  ex_flag_en,
    input  logic [DATA_W-1:0]     ex_result,
    input  flag_t                 ex_flag,
    input  logic                  flush,
    output logic                  wb_valid,
    input  logic                  wb_stall,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_wr_en,
    output logic [DATA_W-1:0]     wb_result,
`ifdef I2D_EX_WB_FWD_EN
    input  logic [REG_ADDR_W-1:0] fwd_rs_a,
    input  logic [REG_ADDR_W-1:0] fwd_rs_b,
    output logic                  fwd_a_hit,
    output logic [DATA_W-1:0]     fwd_a_data,
    output logic                  fwd_b_hit,
    output logic [DATA_W-1:0]     fwd_b_data,
`endif
    output flag_t                 flag_q
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr_en;
        logic [DATA_W-1:0]     result;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t out_q, skid_q, in_entry;
    logic   accept, consume;
    logic   load_out_in, load_out_skid, load_skid;

    // Ready comes from registered state only, so wb_stall never reaches ex_ready combinationally.
    assign ex_ready = (state_q != FULL);
    assign wb_valid = (state_q != EMPTY);
    assign accept   = ex_valid & ex_ready & ~flush;
    assign consume  = wb_valid & ~wb_stall;

    assign in_entry  = '{rd: ex_rd, wr_en: ex_wr_en, result: ex_result};
    assign wb_rd     = out_q.rd;
    assign wb_wr_en  = out_q.wr_en;
    assign wb_result = out_q.result;

    // Next-state and entry-load decode; flush empties the stage regardless of traffic.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    load_out_skid = 1'b1;
                    state_d       = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d       = EMPTY;
            load_out_skid = 1'b0;
        end
    end

    // State and entry registers; OUT always holds the older entry, SKID the newer one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out_in) begin
                out_q <= in_entry;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Flags commit at accept time so the very next instruction sees them, independent of wb_stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else if (accept && ex_flag_en) begin
            flag_q <= ex_flag;
        end
    end

`ifdef I2D_EX_WB_FWD_EN
    // Forward from held entries, newer SKID first; misses return zero data.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        if (state_q == FULL && skid_q.wr_en && skid_q.rd == fwd_rs_a) begin
            fwd_a_hit  = 1'b1;
            fwd_a_data = skid_q.result;
        end else if (state_q != EMPTY && out_q.wr_en && out_q.rd == fwd_rs_a) begin
            fwd_a_hit  = 1'b1;
            fwd_a_data = out_q.result;
        end
        if (state_q == FULL && skid_q.wr_en && skid_q.rd == fwd_rs_b) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = skid_q.result;
        end else if (state_q != EMPTY && out_q.wr_en && out_q.rd == fwd_rs_b) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = out_q.result;
        end
    end
`endif

endmodule

// File: tb/tb_core_ex_wb_reg.sv
// Bench for core_ex_wb_reg: directed scenarios with literal expectations, then random traffic.
// Reference is a queue of in-flight entries plus a flag variable, updated once per clock.
// Outputs are compared on every falling edge once the model has seen a reset.

module tb_core_ex_wb_reg;
    import core_ex_wb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic          ex_ready;
    logic [AW-1:0] ex_rd = '0;
    logic          ex_wr_en = 1'b0;
    logic          ex_flag_en = 1'b0;
    logic [DW-1:0] ex_result = '0;
    flag_t         ex_flag = '0;
    logic          flush = 1'b0;
    logic          wb_valid;
    logic          wb_stall = 1'b0;
    logic [AW-1:0] wb_rd;
    logic          wb_wr_en;
    logic [DW-1:0] wb_result;
    flag_t         flag_q;
    logic [AW-1:0] fwd_rs_a = '0;
    logic [AW-1:0] fwd_rs_b = '0;
`ifdef I2D_EX_WB_FWD_EN
    logic          fwd_a_hit, fwd_b_hit;
    logic [DW-1:0] fwd_a_data, fwd_b_data;
`endif

    core_ex_wb_reg #(.REG_ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_wr_en   (ex_wr_en),
        .ex_flag_en (ex_flag_en),
        .ex_result  (ex_result),
        .ex_flag    (ex_flag),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_stall   (wb_stall),
        .wb_rd      (wb_rd),
        .wb_wr_en   (wb_wr_en),
        .wb_result  (wb_result),
`ifdef I2D_EX_WB_FWD_EN
        .fwd_rs_a   (fwd_rs_a),
        .fwd_rs_b   (fwd_rs_b),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_b_data (fwd_b_data),
`endif
        .flag_q     (flag_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] rd;
        logic          wr_en;
        logic [DW-1:0] result;
    } ent_t;

    ent_t  q[$];
    flag_t m_flag;
    bit    model_ok = 0;
    bit    clean    = 0;   // no accept since reset: output register still holds zeros

    always @(posedge clk) begin
        bit acc, con;
        ent_t e;
        if (rst) begin
            q.delete();
            m_flag   = '0;
            model_ok = 1;
            clean    = 1;
        end else if (model_ok) begin
            acc = ex_valid && (q.size() < 2) && !flush;
            con = (q.size() > 0) && !wb_stall;
            if (con) void'(q.pop_front());
            if (acc) begin
                e.rd = ex_rd; e.wr_en = ex_wr_en; e.result = ex_result;
                q.push_back(e);
                clean = 0;
                if (ex_flag_en) m_flag = ex_flag;
            end
            if (flush) q.delete();
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_wb_valid", 64'(wb_valid), 64'(q.size() > 0));
            chk("m_ex_ready", 64'(ex_ready), 64'(q.size() < 2));
            chk("m_flag_q", 64'(flag_q), 64'(m_flag));
            if (q.size() > 0) begin
                chk("m_wb_rd", 64'(wb_rd), 64'(q[0].rd));
                chk("m_wb_wr_en", 64'(wb_wr_en), 64'(q[0].wr_en));
                chk("m_wb_result", 64'(wb_result), 64'(q[0].result));
            end else if (clean) begin
                chk("m_wb_rd_zero", 64'(wb_rd), 64'd0);
                chk("m_wb_result_zero", 64'(wb_result), 64'd0);
                chk("m_wb_wr_en_zero", 64'(wb_wr_en), 64'd0);
            end
`ifdef I2D_EX_WB_FWD_EN
            begin
                logic          ha, hb;
                logic [DW-1:0] da, db;
                ha = 0; hb = 0; da = '0; db = '0;
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!ha && q[i].wr_en && q[i].rd == fwd_rs_a) begin ha = 1; da = q[i].result; end
                    if (!hb && q[i].wr_en && q[i].rd == fwd_rs_b) begin hb = 1; db = q[i].result; end
                end
                chk("m_fwd_a_hit", 64'(fwd_a_hit), 64'(ha));
                chk("m_fwd_a_data", 64'(fwd_a_data), 64'(da));
                chk("m_fwd_b_hit", 64'(fwd_b_hit), 64'(hb));
                chk("m_fwd_b_data", 64'(fwd_b_data), 64'(db));
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic we,
                         input logic fe, input logic [DW-1:0] res, input flag_t fl);
        ex_valid = v; ex_rd = rd; ex_wr_en = we; ex_flag_en = fe; ex_result = res; ex_flag = fl;
    endtask

    initial begin
        // Reset then single accept
        rst = 1; cyc(); cyc();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_result", 64'(wb_result), 64'd0);
        chk("rst_flag_q", 64'(flag_q), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        rst = 0; wb_stall = 0;
        drive(1, 4'd3, 1, 1, 32'h0000_00A5, '{cf: 1'b1, of: 1'b0, zf: 1'b0});
        cyc();
        chk("single_wb_valid", 64'(wb_valid), 64'd1);
        chk("single_wb_rd", 64'(wb_rd), 64'd3);
        chk("single_wb_result", 64'(wb_result), 64'hA5);
        chk("single_cf", 64'(flag_q.cf), 64'd1);
        drive(0, 0, 0, 0, 0, '0);
        cyc();
        chk("single_drain", 64'(wb_valid), 64'd0);

        // Skid fill under stall
        wb_stall = 1;
        drive(1, 4'd1, 1, 0, 32'd1, '0); cyc();
        drive(1, 4'd2, 1, 0, 32'd2, '0); cyc();
        chk("skid_ready_low", 64'(ex_ready), 64'd0);
        chk("skid_hold1", 64'(wb_result), 64'd1);
        drive(0, 0, 0, 0, 0, '0); cyc();
        chk("skid_hold2", 64'(wb_result), 64'd1);
        chk("skid_valid_held", 64'(wb_valid), 64'd1);
        wb_stall = 0; cyc();
        chk("skid_second", 64'(wb_result), 64'd2);
        chk("skid_ready_back", 64'(ex_ready), 64'd1);
        cyc();
        chk("skid_drained", 64'(wb_valid), 64'd0);

        // Flag hold when flag_en is low, then a zf-only update
        drive(1, 4'd4, 1, 1, 32'd0, '0); cyc();
        drive(1, 4'd4, 1, 0, 32'd0, '{cf: 1'b1, of: 1'b1, zf: 1'b1}); cyc();
        chk("flag_hold", 64'(flag_q), 64'd0);
        drive(1, 4'd4, 1, 1, 32'd0, '{cf: 1'b0, of: 1'b0, zf: 1'b1}); cyc();
        chk("flag_zf_only", 64'(flag_q), 64'b001);
        drive(0, 0, 0, 0, 0, '0); cyc(); cyc();

        // Flush in FULL with a same-cycle flag-updating instruction
        wb_stall = 1;
        drive(1, 4'd7, 1, 0, 32'd7, '0); cyc();
        drive(1, 4'd8, 1, 0, 32'd8, '0); cyc();
        chk("flush_pre_full", 64'(ex_ready), 64'd0);
        flush = 1;
        drive(1, 4'd9, 1, 1, 32'd9, '{cf: 1'b1, of: 1'b0, zf: 1'b0}); cyc();
        chk("flush_valid", 64'(wb_valid), 64'd0);
        chk("flush_cf_kept", 64'(flag_q.cf), 64'd0);
        flush = 0; wb_stall = 0;
        drive(0, 0, 0, 0, 0, '0); cyc();
        chk("flush_no_reappear1", 64'(wb_valid), 64'd0);
        cyc();
        chk("flush_no_reappear2", 64'(wb_valid), 64'd0);

        // Reset while FULL
        wb_stall = 1;
        drive(1, 4'd2, 1, 1, 32'd9, '{cf: 1'b1, of: 1'b1, zf: 1'b1}); cyc();
        drive(1, 4'd3, 1, 1, 32'd10, '{cf: 1'b1, of: 1'b1, zf: 1'b1}); cyc();
        chk("rstfull_pre", 64'(ex_ready), 64'd0);
        rst = 1; drive(0, 0, 0, 0, 0, '0); cyc();
        chk("rstfull_valid", 64'(wb_valid), 64'd0);
        chk("rstfull_result", 64'(wb_result), 64'd0);
        chk("rstfull_flag", 64'(flag_q), 64'd0);
        chk("rstfull_ready", 64'(ex_ready), 64'd1);
        rst = 0;

`ifdef I2D_EX_WB_FWD_EN
        // Forwarding with both entries targeting the same register
        drive(1, 4'd5, 1, 0, 32'd10, '0); cyc();
        drive(1, 4'd5, 1, 0, 32'd20, '0); cyc();
        drive(0, 0, 0, 0, 0, '0);
        fwd_rs_a = 4'd5; fwd_rs_b = 4'd6; #1;
        chk("fwd_a_hit", 64'(fwd_a_hit), 64'd1);
        chk("fwd_a_data", 64'(fwd_a_data), 64'd20);
        chk("fwd_b_hit", 64'(fwd_b_hit), 64'd0);
        chk("fwd_b_data", 64'(fwd_b_data), 64'd0);
        wb_stall = 0; cyc(); cyc();
`endif

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            flag_t fl;
            fl = flag_t'($urandom_range(0, 7));
            drive(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 15)), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom, fl);
            wb_stall = ($urandom_range(0, 9) < 4);
            flush    = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            fwd_rs_a = AW'($urandom_range(0, 15));
            fwd_rs_b = AW'($urandom_range(0, 15));
            cyc();
        end
        rst = 0; flush = 0; drive(0, 0, 0, 0, 0, '0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
